// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer behind the 4-bit PISO: rebuilds MSB-first words into a one-entry valid/ready buffer.
// Define PARITY_CHECK_EN to add a trailing even-parity bit (PAR state) and drive par_err.
module sipo_deframer #(
  parameter int WIDTH = 4,
  localparam int CNTW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             abort,
  output logic             overflow,
  output logic             par_err
);

  // Without parity the last bit goes straight from sin into the word, so one fewer stored bit is needed.
`ifdef PARITY_CHECK_EN
  localparam int SHW = WIDTH;
`else
  localparam int SHW = WIDTH - 1;
`endif
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [SHW-1:0]   shreg, shreg_nxt;
  logic             abort_nxt;
  logic             done;
  logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  logic             perr_nxt;
  logic             par_err_q;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    abort_nxt = 1'b0;
    done      = 1'b0;
    word      = '0;
`ifdef PARITY_CHECK_EN
    perr_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          // restart: an empty partial frame (start held high) is not reported as an abort
          cnt_nxt   = '0;
          shreg_nxt = '0;
          abort_nxt = (cnt != '0);
        end else begin
          shreg_nxt = SHW'({shreg, sin});
          if (cnt == LAST) begin
            cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
            done      = 1'b1;
            word      = {shreg, sin};
`endif
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = '0;
          abort_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          done      = 1'b1;
          word      = shreg;
          perr_nxt  = (^shreg) ^ sin;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      abort     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
      abort <= abort_nxt;
      if (done) begin
        // a consume on the same edge frees the buffer, so the new word lands without a gap
        if (!out_valid || out_ready) begin
          out_data  <= word;
          out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
          par_err_q <= perr_nxt;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef PARITY_CHECK_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-in, parallel-out receiver sitting directly downstream of the 4-bit PISO shift register stage; it consumes that stage's serial output `q` and its load strobe `s`.
- It rebuilds parallel words, MSB first, using a bit counter and a small FSM.
- Each completed word is held in a one-entry output buffer with a valid/ready handshake, so the next lab stage (display/ALU) can accept it at its own pace.

Parameters:
- WIDTH, 4, number of data bits per frame; legal range 2..16.
- CNTW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream PISO.
- rst  input  1  asynchronous active-high reset.
- sin  input  1  serial data; connects to the PISO `q`.
- start  input  1  frame-start strobe; connects to the PISO `s` (load). High = upstream is loading a new word.
- out_data  output  WIDTH  reassembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on a clock edge where out_valid && out_ready.
- busy  output  1  high while a frame is being shifted in.
- abort  output  1  one-cycle pulse when a partial frame is discarded by a new start.
- overflow  output  1  sticky; a completed word was dropped because the buffer was full.
- par_err  output  1  parity error flag for the word in out_data; only meaningful with PARITY_CHECK_EN.

Behaviour:
- Reset (async, rst=1): all outputs are 0, including out_data. FSM=IDLE, cnt=0, shift register=0. Reset mid-frame discards the partial word and any buffered word.
- States:
  - IDLE: busy=0. An edge with start=1 moves to SHIFT with cnt=0. No sample is taken on that edge.
  - SHIFT: busy=1. While start=0, each edge samples sin into shreg = {shreg[WIDTH-2:0], sin} and increments cnt, so the first sampled bit ends up in the MSB. On the edge sampling bit WIDTH-1 (cnt==WIDTH-1), the word is delivered and the FSM returns to IDLE (or PAR when the parity feature is enabled).
  - start=1 while in SHIFT: the partial frame is dropped, cnt=0, the FSM stays in SHIFT, abort=1 for the next cycle, and no sample is taken on that edge.
  - start held high for several cycles: the FSM remains in SHIFT with cnt=0. Sampling begins on the first edge where start=0.
- Word delivery: the completed word is written into out_data on the same edge that samples its last bit. out_valid is high starting the cycle after that edge.
  - Latency: with WIDTH=4, a start edge at edge N gives samples at N+1..N+4, and out_valid is high after edge N+4.
- Handshake:
  - out_valid stays high, and out_data stays stable, until an edge with out_ready=1.
  - Consume only (out_valid && out_ready, no word completing): out_valid goes to 0 on that edge.
  - Completion while the buffer is empty: the new word is loaded.
  - Completion on the same edge as a consume: the new word is loaded and out_valid stays 1 with no gap.
  - Completion while out_valid=1 and out_ready=0: the new word is dropped, the buffer is unchanged, and overflow is set to 1. overflow clears only on rst.
- Counter: cnt never exceeds WIDTH-1 and returns to 0 on every return to IDLE and on every abort.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - An extra state PAR follows SHIFT.
  - The edge after bit WIDTH-1 samples an even-parity bit from sin.
  - The word and par_err (= ^word ^ paritybit) are loaded together on the PAR edge, so latency grows by one edge.
  - start during PAR aborts exactly as it does in SHIFT.
  - Overflow rules apply at the PAR edge.
- Undefined: there is no PAR state, and par_err is tied to 0. The port list is identical in both builds.

Test Plan:
- WIDTH=4: rst pulse, then start=1 for one edge, then sin=0,0,1,1 on the next 4 edges -> out_valid=1 and out_data=4'b0011 after the 4th sample edge; busy=1 for exactly 4 cycles.
- Back-to-back frames 1010 then 0110, with out_ready tied to 1 -> two words delivered in order with no lost frame; overflow=0.
- Hold out_ready=0 and send two frames 1111 then 0001 -> out_data stays 4'b1111 and overflow=1 after the second frame completes. Then out_ready=1 for one edge -> out_valid=0.
- After 2 bits (1,1), assert start again, then send 0,1,0,1 -> abort pulses for one cycle; out_data=4'b0101 and the partial bits are discarded.
- Assert rst asynchronously mid-frame (between edges) -> all outputs are 0 immediately. A frame 1001 sent after rst is released is received correctly.
- With PARITY_CHECK_EN: send data 0011 + parity 0 -> par_err=0. Send data 0111 + parity 0 -> par_err=1. out_valid appears one edge later than in the base build.
